// File: rtl/mux_1x8_rr_arbiter_if.sv
// Request/grant bundle between the 8 requesters and the mux arbiter.
// The master modport is the arbiter side; the slave modport is the requester side.
interface mux_1x8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;

  modport master (
    input  req,
    output gnt,
    output sel,
    output busy
  );

  modport slave (
    output req,
    input  gnt,
    input  sel,
    input  busy
  );
endinterface

// File: rtl/mux_1x8_rr_arbiter.sv
// Round-robin arbiter driving the select of an 8:1 routing mux, with a bounded
// hold time per owner so every active requester is served within 8*MAX_HOLD cycles.
module mux_1x8_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  mux_1x8_rr_arbiter_if.master       bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             busy_q, busy_d;

  logic [2:0]       owner;
  logic [7:0]       others;

  // First set bit of mask scanning upward from start, wrapping 7->0.
  function automatic logic [2:0] rr_pick(input logic [7:0] mask, input logic [2:0] start);
    logic [2:0] idx;
    rr_pick = start;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    owner   = sel_q;
    others  = bus.req & ~(8'd1 << owner);

    unique case (state_q)
      IDLE: begin
        if (bus.req != 8'd0) begin
          sel_d   = rr_pick(bus.req, ptr_q);
          gnt_d   = 8'd1 << sel_d;
          busy_d  = 1'b1;
          cnt_d   = '0;
          ptr_d   = sel_d + 3'd1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!bus.req[owner]) begin
          if (bus.req != 8'd0) begin
            sel_d = rr_pick(bus.req, ptr_q);
            gnt_d = 8'd1 << sel_d;
            cnt_d = '0;
            ptr_d = sel_d + 3'd1;
          end else begin
            gnt_d   = 8'd0;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          // Owner has used its slot; it is excluded from the search while others wait.
          cnt_d = '0;
          if (others != 8'd0) begin
            sel_d = rr_pick(others, owner + 3'd1);
            gnt_d = 8'd1 << sel_d;
            ptr_d = sel_d + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_mux_1x8_rr_arbiter.sv
// Bench for mux_1x8_rr_arbiter: directed scenarios plus random request traffic,
// compared every cycle against a queue-free ownership model of the arbitration rules.
module tb_mux_1x8_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  // model: current owner (-1 when idle), cycles held so far, search start, last select
  int m_owner;
  int m_held;
  int m_ptr;
  int m_sel;

  mux_1x8_rr_arbiter_if bus ();

  mux_1x8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] mask, input int start);
    for (int k = 0; k < 8; k++) begin
      if (mask[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic give(input int w);
    m_owner = w;
    m_held  = 1;
    m_ptr   = (w + 1) % 8;
    m_sel   = w;
  endtask

  task automatic modelStep(input logic rst, input logic [7:0] r);
    logic [7:0] others;
    if (rst) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      if (r != 8'd0) give(pick(r, m_ptr));
    end else if (!r[m_owner]) begin
      if (r != 8'd0) give(pick(r, m_ptr));
      else begin m_owner = -1; m_held = 0; end
    end else if (m_held == MAX_HOLD) begin
      others = r;
      others[m_owner] = 1'b0;
      if (others != 8'd0) give(pick(others, (m_owner + 1) % 8));
      else m_held = 1;
    end else begin
      m_held++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
    end
  endtask

  // One clock: drive away from the edge, step the model on the edge, sample 1ns later.
  task automatic applyStimulus(input logic rst, input logic [7:0] r);
    logic [7:0] exp_gnt;
    @(negedge clk);
    reset   = rst;
    bus.req = r;
    @(posedge clk);
    modelStep(rst, r);
    #1;
    exp_gnt = (m_owner < 0) ? 8'd0 : (8'd1 << m_owner);
    checkOutput("gnt", bus.gnt, exp_gnt);
    checkOutput("sel", {5'd0, bus.sel}, 8'(m_sel));
    checkOutput("busy", {7'd0, bus.busy}, {7'd0, m_owner >= 0});
    checkOutput("onehot0", {7'd0, $onehot0(bus.gnt)}, 8'd1);
  endtask

  task automatic holdReq(input logic [7:0] r, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, r);
  endtask

  initial begin
    logic [7:0] r;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.req     = 8'd0;
    m_owner = -1; m_held = 0; m_ptr = 0; m_sel = 0;

    $display("[TB] reset during activity, then full-load fairness");
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'hFF);
    checkOutput("reset_gnt", bus.gnt, 8'h00);
    applyStimulus(1'b0, 8'hFF);
    checkOutput("first_gnt", bus.gnt, 8'h01);
    holdReq(8'hFF, 3);
    applyStimulus(1'b0, 8'hFF);
    checkOutput("rotate_sel", {5'd0, bus.sel}, 8'd1);
    holdReq(8'hFF, 36);

    $display("[TB] single requester saturates");
    applyStimulus(1'b1, 8'h00);
    holdReq(8'h08, 10);
    checkOutput("single_gnt", bus.gnt, 8'h08);
    applyStimulus(1'b0, 8'h00);
    checkOutput("drop_sel", {5'd0, bus.sel}, 8'd3);
    holdReq(8'h00, 2);

    $display("[TB] early release with no bubble");
    applyStimulus(1'b1, 8'h00);
    holdReq(8'h04, 2);
    applyStimulus(1'b0, 8'h44);
    applyStimulus(1'b0, 8'h40);
    checkOutput("handoff_gnt", bus.gnt, 8'h40);
    holdReq(8'h40, 2);

    $display("[TB] wrap-around past an idle index 7");
    applyStimulus(1'b1, 8'h00);
    holdReq(8'h40, 2);
    applyStimulus(1'b0, 8'h03);
    checkOutput("wrap_gnt", bus.gnt, 8'h01);
    holdReq(8'h03, 4);
    checkOutput("wrap_next", bus.gnt, 8'h02);

    $display("[TB] simultaneous drop and raise");
    applyStimulus(1'b1, 8'h00);
    holdReq(8'h10, 2);
    applyStimulus(1'b0, 8'h02);
    checkOutput("swap_gnt", bus.gnt, 8'h02);
    holdReq(8'h02, 2);

    $display("[TB] random traffic");
    r = 8'd0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      else r = r ^ (8'd1 << $urandom_range(0, 7));
      applyStimulus($urandom_range(0, 60) == 0, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_1x8_rr_arbiter.md
Name: mux_1x8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the 8:1 routing multiplexer (multiplexeur_1x8).
- Shares the single mux output among 8 requesters.
- Drives the mux 3-bit select, one-hot grants and a busy flag.
- Bounds how long one requester may hold the mux, so every active requester is served within 8*MAX_HOLD cycles.

Parameters:
- MAX_HOLD, 4, max consecutive grant cycles for one requester while others are pending; legal range 1..8.
- CNT_W, 3, width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request per mux input; req[i] pairs with mux data input i (a..h = 0..7).
- gnt  output  8  one-hot grant, registered; all-zero when idle.
- sel  output  3  mux select, registered; equals index of the set gnt bit.
- busy  output  1  registered; 1 while any gnt bit is set.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset:
  - On any rising edge with reset=1: gnt=0, sel=0, busy=0, ptr=0, cnt=0, state=IDLE.
  - Reset overrides all other activity, including an in-progress grant; the grant drops on that edge.
- Internal state:
  - ptr (3 bits): round-robin search start.
  - cnt (CNT_W bits): cycles the current owner has held the grant.
  - state: IDLE or GRANT.
- Winner search:
  - Scan req from index ptr upward, wrapping 7->0.
  - The first set bit wins; ptr=5 with req=8'b0010_0001 picks 5.
- IDLE:
  - At an edge with req!=0: grant the winner. gnt=1<<w, sel=w, busy=1, cnt=0, ptr=w+1 (mod 8), state=GRANT.
  - Latency is one edge: req sampled at edge k gives gnt valid after edge k.
  - If req==0: stay IDLE; sel keeps its last value.
- GRANT, owner o = sel, evaluated at each edge:
  - Release case, req[o]==0:
    - If another requester is pending, switch directly to the winner searched from ptr (=o+1), with no idle bubble; cnt=0.
    - Otherwise go IDLE: gnt=0, busy=0, sel holds o.
  - Preempt case, req[o]==1, cnt==MAX_HOLD-1, and another req pending:
    - Switch to the winner searched from o+1.
    - Owner o is excluded from this search even though it still requests.
  - Saturate case, req[o]==1, cnt==MAX_HOLD-1, no other req:
    - Keep o and reset cnt to 0.
  - Otherwise: keep o and increment cnt.
- Every switch sets ptr to winner+1 (mod 8).
- Invariants:
  - gnt is always zero or one-hot.
  - sel==index(gnt) whenever busy=1.
  - gnt, sel and busy change only on clock edges.
  - Never glitch sel mid-cycle.
- Simultaneous events:
  - Owner drops req on the same edge another asserts: treat as a switch to the new requester.
  - All 8 request at once: served in order ptr, ptr+1, ... with MAX_HOLD cycles each.
- Wrap-around: after owner 7, ptr=0.
- Reset mid-grant: next edge after reset deasserts starts from ptr=0, with state IDLE.

Test Plan:
- Reset during activity: reset=1 with req=8'hFF for 2 edges -> gnt=0, sel=0, busy=0. Release reset -> gnt=8'h01, sel=0 one edge later.
- Single requester: req=8'b0000_1000 held 10 cycles -> gnt=8'h08, sel=3 for all 10 cycles (saturate case, no preemption). Drop req -> gnt=0, busy=0, sel stays 3.
- Fairness, MAX_HOLD=4: req=8'hFF continuously from reset -> sel sequence 0,0,0,0,1,1,1,1,...,7,7,7,7,0. Each index is held exactly 4 cycles.
- Early release, no bubble: owner 2 granted, req=8'b0100_0100; drop req[2] -> next edge gnt=8'h40, sel=6, busy stays 1 throughout.
- Wrap-around: after owner 6 releases with ptr=7 and req=8'b0000_0011 -> winner 0 (gnt=8'h01), then winner 1 after its hold. Index 7 is skipped because it does not request.
- Simultaneous drop/raise: owner 4, req[4] falls on the same edge req[1] rises -> gnt=8'h02, sel=1 after that edge. gnt is never 0 between the two grants.
